// File: rtl/arp_table_arbiter.sv
// ARP table (next-hop IPv4 -> MAC) with a single access path shared between
// sequential datapath lookups and software register reads/writes.
module arp_table_arbiter #(
    parameter int unsigned TABLE_DEPTH        = 32,
    parameter int unsigned IDX_BITS           = 5,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          AXI_ACLK,
    input  logic                          reset,

    input  logic                          lookup_req,
    input  logic [31:0]                   lookup_ip,
    output logic                          lookup_ack,
    output logic                          lookup_hit,
    output logic [47:0]                   lookup_mac,

    input  logic                          sw_wr_req,
    input  logic                          sw_rd_req,
    input  logic [IDX_BITS-1:0]           sw_addr,
    input  logic [31:0]                   sw_wr_ip,
    input  logic [47:0]                   sw_wr_mac,
    input  logic                          sw_wr_valid,
    output logic                          sw_ack,
    output logic [31:0]                   sw_rd_ip,
    output logic [47:0]                   sw_rd_mac,
    output logic                          sw_rd_valid,

    output logic [C_S_AXI_DATA_WIDTH-1:0] lookup_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] hit_count
);

    localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(TABLE_DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StLuDone,
        StSwDone
    } state_e;

    state_e state_q, state_d;

    logic               entry_valid_q [TABLE_DEPTH];
    logic [31:0]        entry_ip_q    [TABLE_DEPTH];
    logic [47:0]        entry_mac_q   [TABLE_DEPTH];

    logic [31:0]         ip_q;
    logic [IDX_BITS-1:0] idx_q;
    // 1 = software won the most recent tie, 0 = lookup won it
    logic                last_sw_q, last_sw_d;

    logic sw_pend;
    logic addr_ok;
    logic grant_lu;
    logic grant_sw;
    logic scan_match;
    logic scan_done;

    assign sw_pend = sw_wr_req | sw_rd_req;
    assign addr_ok = (32'(sw_addr) < TABLE_DEPTH);

    assign lookup_ack = (state_q == StLuDone);
    assign sw_ack     = (state_q == StSwDone);

    always_comb begin
        state_d    = state_q;
        last_sw_d  = last_sw_q;
        grant_lu   = 1'b0;
        grant_sw   = 1'b0;
        scan_done  = 1'b0;
        scan_match = entry_valid_q[idx_q] && (entry_ip_q[idx_q] == ip_q);

        case (state_q)
            StIdle: begin
                if (lookup_req && sw_pend) begin
                    // Tie: serve the side that did not win the previous tie
                    grant_sw  = ~last_sw_q;
                    grant_lu  = last_sw_q;
                    last_sw_d = ~last_sw_q;
                end else begin
                    grant_lu = lookup_req;
                    grant_sw = sw_pend;
                end
                if (grant_lu) begin
                    state_d = StScan;
                end else if (grant_sw) begin
                    state_d = StSwDone;
                end
            end
            StScan: begin
                scan_done = scan_match || (idx_q == LastIdx);
                if (scan_done) begin
                    state_d = StLuDone;
                end
            end
            StLuDone: state_d = StIdle;
            StSwDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state_q      <= StIdle;
            last_sw_q    <= 1'b0;
            ip_q         <= '0;
            idx_q        <= '0;
            lookup_hit   <= 1'b0;
            lookup_mac   <= '0;
            sw_rd_ip     <= '0;
            sw_rd_mac    <= '0;
            sw_rd_valid  <= 1'b0;
            lookup_count <= '0;
            hit_count    <= '0;
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                entry_valid_q[i] <= 1'b0;
                entry_ip_q[i]    <= '0;
                entry_mac_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            last_sw_q <= last_sw_d;

            if (grant_lu) begin
                ip_q  <= lookup_ip;
                idx_q <= '0;
            end

            if (state_q == StScan) begin
                if (scan_done) begin
                    lookup_hit <= scan_match;
                    lookup_mac <= scan_match ? entry_mac_q[idx_q] : 48'h0;
                end else begin
                    idx_q <= idx_q + IDX_BITS'(1);
                end
            end

            if (state_q == StLuDone) begin
                lookup_count <= lookup_count + C_S_AXI_DATA_WIDTH'(1);
                if (lookup_hit) begin
                    hit_count <= hit_count + C_S_AXI_DATA_WIDTH'(1);
                end
            end

            if (grant_sw) begin
                if (sw_wr_req && addr_ok) begin
                    entry_valid_q[sw_addr] <= sw_wr_valid;
                    entry_ip_q[sw_addr]    <= sw_wr_ip;
                    entry_mac_q[sw_addr]   <= sw_wr_mac;
                end
                // Write+read returns the entry as it will be after the write
                if (sw_rd_req) begin
                    if (!addr_ok) begin
                        sw_rd_valid <= 1'b0;
                        sw_rd_ip    <= '0;
                        sw_rd_mac   <= '0;
                    end else if (sw_wr_req) begin
                        sw_rd_valid <= sw_wr_valid;
                        sw_rd_ip    <= sw_wr_ip;
                        sw_rd_mac   <= sw_wr_mac;
                    end else begin
                        sw_rd_valid <= entry_valid_q[sw_addr];
                        sw_rd_ip    <= entry_ip_q[sw_addr];
                        sw_rd_mac   <= entry_mac_q[sw_addr];
                    end
                end
            end
        end
    end

endmodule
